// File: rtl/line_buffer_3x3_pkg.sv
// rtl/line_buffer_3x3_pkg.sv - shared image geometry and pixel width for the 3x3 window path
//
// Purpose: default image dimensions, pixel width and counter widths shared by the
//          line buffer, the window extractor and the convolution stage.
// Ports:   none (package).
package line_buffer_3x3_pkg;

  localparam int PIX_W     = 8;
  localparam int IMG_W_DEF = 64;
  localparam int IMG_H_DEF = 64;

  // Width of a counter or address that spans 0..n-1; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int COL_W_DEF = cnt_width(IMG_W_DEF);
  localparam int ROW_W_DEF = cnt_width(IMG_H_DEF);

endpackage

// File: rtl/line_buffer_3x3_line_ram.sv
// rtl/line_buffer_3x3_line_ram.sv - single-address read-old/write-new line memory
//
// Purpose: DEPTH x PIX_W row store. One read and one write per cycle at the same
//          address; the read returns the contents from before this cycle's write.
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   addr_i   in   shared read/write address
//   wdata_i  in   write data
//   rdata_o  out  old data at addr_i (combinational read)
module line_ram
  import line_buffer_3x3_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int AW    = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [PIX_W-1:0] wdata_i,
  output logic [PIX_W-1:0] rdata_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  // Asynchronous read sees the pre-edge contents, giving read-before-write.
  assign rdata_o = mem_q[addr_i];

  // Contents are deliberately not reset; stale data is masked by row2_cond.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/line_buffer_3x3.sv
// rtl/line_buffer_3x3.sv - raster line buffer producing a sliding 3x3 pixel window
//
// Purpose: keeps two image rows plus a 3-column tap register and emits a 3x3
//          neighbourhood per accepted pixel, one cycle after accept.
// Ports:
//   clk                      in   clock
//   rstb                     in   asynchronous active-low reset
//   pix_in / pix_valid       in   pixel stream
//   pix_sof                  in   start of frame, forces the pixel to (0,0)
//   pix_ready                out  equals win_ready
//   win_ready                in   downstream ready
//   out_data_1..out_data_9   out  taps: rows r-2, r-1, r; cols c-2..c each
//   buf_valid                out  taps hold a window not yet consumed
//   row2_cond                out  window lies fully inside the image
module line_buffer_3x3
  import line_buffer_3x3_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             pix_sof,
  output logic             pix_ready,
  input  logic             win_ready,
  output logic [PIX_W-1:0] out_data_1,
  output logic [PIX_W-1:0] out_data_2,
  output logic [PIX_W-1:0] out_data_3,
  output logic [PIX_W-1:0] out_data_4,
  output logic [PIX_W-1:0] out_data_5,
  output logic [PIX_W-1:0] out_data_6,
  output logic [PIX_W-1:0] out_data_7,
  output logic [PIX_W-1:0] out_data_8,
  output logic [PIX_W-1:0] out_data_9,
  output logic             buf_valid,
  output logic             row2_cond
);

  localparam int COL_W = cnt_width(IMG_W);
  localparam int ROW_W = cnt_width(IMG_H);

  logic             acc;
  logic [COL_W-1:0] col_q, col_d, col_eff;
  logic [ROW_W-1:0] row_q, row_d, row_eff;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic [PIX_W-1:0] tap_q [9];
  logic [PIX_W-1:0] tap_d [9];
  logic             buf_valid_q, buf_valid_d;
  logic             row2_cond_q, row2_cond_d;

  // No skid buffer: we only take a pixel when downstream takes the window.
  assign pix_ready = win_ready;
  assign acc       = pix_valid & win_ready;

  // An accepted sof pixel is (0,0) regardless of where the counters are.
  assign col_eff = pix_sof ? '0 : col_q;
  assign row_eff = pix_sof ? '0 : row_q;

  // lb0 holds row r-1, lb1 holds row r-2; lb1 is refilled from lb0's old word.
  line_ram #(.DEPTH(IMG_W), .AW(COL_W)) u_lb0 (
    .clk     (clk),
    .we_i    (acc),
    .addr_i  (col_eff),
    .wdata_i (pix_in),
    .rdata_o (lb0_rd)
  );

  line_ram #(.DEPTH(IMG_W), .AW(COL_W)) u_lb1 (
    .clk     (clk),
    .we_i    (acc),
    .addr_i  (col_eff),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    tap_d       = tap_q;
    buf_valid_d = buf_valid_q;
    row2_cond_d = row2_cond_q;

    if (acc) begin
      if (col_eff == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_eff == ROW_W'(IMG_H - 1)) ? '0 : row_eff + ROW_W'(1);
      end else begin
        col_d = col_eff + COL_W'(1);
        row_d = row_eff;
      end

      // Each tap row shifts left; the new right column is {lb1, lb0, pixel}.
      tap_d[0] = tap_q[1];
      tap_d[1] = tap_q[2];
      tap_d[2] = lb1_rd;
      tap_d[3] = tap_q[4];
      tap_d[4] = tap_q[5];
      tap_d[5] = lb0_rd;
      tap_d[6] = tap_q[7];
      tap_d[7] = tap_q[8];
      tap_d[8] = pix_in;

      buf_valid_d = 1'b1;
      row2_cond_d = (row_eff >= ROW_W'(2)) && (col_eff >= COL_W'(2));
    end else if (win_ready) begin
      // Downstream consumed the window and nothing replaced it.
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      col_q       <= '0;
      row_q       <= '0;
      buf_valid_q <= 1'b0;
      row2_cond_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        tap_q[i] <= '0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      buf_valid_q <= buf_valid_d;
      row2_cond_q <= row2_cond_d;
      tap_q       <= tap_d;
    end
  end

  assign out_data_1 = tap_q[0];
  assign out_data_2 = tap_q[1];
  assign out_data_3 = tap_q[2];
  assign out_data_4 = tap_q[3];
  assign out_data_5 = tap_q[4];
  assign out_data_6 = tap_q[5];
  assign out_data_7 = tap_q[6];
  assign out_data_8 = tap_q[7];
  assign out_data_9 = tap_q[8];
  assign buf_valid  = buf_valid_q;
  assign row2_cond  = row2_cond_q;

endmodule
